multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the 3-bit-opcode processor (add, sub, lwd, swd, slt, beq, swp, lim).
- Steps the datapath through fetch, execute, memory and writeback, and emits the per-cycle enables the single-cycle decoder cannot express.
- Covers the multi-cycle operations: data-memory wait handshake, the two-write swp, and branch PC select.
- Sits between the program-start/ack interface and the PC, IR, register file, ALU and data memory.

Parameters:
- WAIT_MAX, 15: maximum MemReady-low cycles tolerated in MEM before error abort.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock; one clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin program execution; level, sampled only in IDLE.
- Op  in  3  opcode from IR; valid from the cycle after IRLoad until the next IRLoad.
- Zero  in  1  ALU equality flag; valid during EXEC.
- MemReady  in  1  data memory has completed the access this cycle.
- HaltIn  in  1  current instruction is the last one; sampled in its final cycle.
- IRLoad  out  1  load IR from instruction memory.
- PCEn  out  1  update PC at the next edge.
- PCBranch  out  1  PC takes the branch target; otherwise PC+1.
- ALUOp  out  1  0 = add, 1 = subtract.
- WriteSrc  out  2  regfile write source: 00 ALU, 01 memory, 10 slt, 11 other/none.
- RegWrite  out  1  register file write enable.
- RegWriteSel  out  1  swp destination select: 0 = first write, 1 = second write.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- Ack  out  1  program finished; held in DONE.
- Err  out  1  memory timeout abort; held in DONE.
- InstrCount  out  CNT_W  retired instructions; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high) takes effect at the next edge from any state, including mid-MEM.
  - State goes to IDLE.
  - WaitCnt, InstrCount, Ack and Err clear to 0.
  - All outputs are 0 the cycle after Reset, except WriteSrc = 11.
- Outputs are decoded from state and Op (Moore, plus Op decode); no output is registered beyond state.
- Default outputs: enables 0, WriteSrc 11, ALUOp 0.
- States and transitions:
  - IDLE: stays until Start=1, then FETCH. Start in any other state is ignored.
  - FETCH: IRLoad=1; goes to EXEC.
  - EXEC: drives ALUOp and WriteSrc per Op, using the same encoding as the decoder: add 00/0, sub 00/1, lwd 01/0, swd 11/0, slt 10/0, beq 11/1, swp 11/0, lim 11/0.
    - add, sub, slt, lim, swp: go to WB.
    - lwd, swd: go to MEM, with WaitCnt cleared to 0.
    - beq: final cycle; PCEn=1 and PCBranch=Zero.
  - MEM: lwd asserts MemRead=1; swd asserts MemWrite=1. The request is held until MemReady=1.
    - MemReady=1: lwd goes to WB; for swd this is the final cycle, with PCEn=1.
    - MemReady=0 and WaitCnt<WAIT_MAX: WaitCnt increments.
    - MemReady=0 and WaitCnt==WAIT_MAX: go to DONE with Err set. PC is not updated and the instruction is not counted.
    - If MemReady and the timeout coincide, MemReady wins.
  - WB: RegWrite=1, WriteSrc per Op (lwd 01).
    - swp: RegWriteSel=0, go to SWP2.
    - All other ops: final cycle, PCEn=1.
  - SWP2: RegWrite=1, RegWriteSel=1, WriteSrc=11; final cycle, PCEn=1.
  - DONE: Ack=1 (or Err=1); moves to IDLE when Start=0. Ack and Err clear on leaving DONE.
- Final cycle of every instruction:
  - InstrCount increments (saturating).
  - If HaltIn=1, next state is DONE with Ack set; otherwise FETCH.
- Latency from FETCH to the final cycle, inclusive:
  - beq: 2 cycles.
  - add, sub, slt, lim, swd: 3 cycles (swd with MemReady in the first MEM cycle).
  - lwd, swp: 4 cycles (lwd with MemReady in the first MEM cycle).
  - Each MemReady-low cycle adds 1.
- MemRead and MemWrite are never asserted together. RegWrite is never asserted in FETCH, EXEC or MEM.

Test Plan:
- Reset, Start=1, Op=000 (add), HaltIn=0: FETCH, EXEC, WB; WB shows RegWrite=1, WriteSrc=00, PCEn=1; InstrCount=1 after 3 cycles.
- Op=101 (beq): Zero=1 gives a 2-cycle instruction with PCEn=1, PCBranch=1, ALUOp=1. Repeat with Zero=0: PCBranch=0.
- Op=010 (lwd), MemReady low for 3 cycles: MemRead=1 for 4 cycles, then WB with WriteSrc=01, RegWrite=1; total 7 cycles. Op=011 (swd), MemReady=1 immediately: MemWrite=1 for one cycle, no RegWrite.
- Op=110 (swp): two consecutive RegWrite cycles, RegWriteSel 0 then 1; PCEn only in the second.
- Op=010, MemReady held at 0: after 16 MEM cycles go to DONE with Err=1 and Ack=0; InstrCount unchanged; Start=0 returns to IDLE.
- HaltIn=1 on an add: DONE with Ack=1 held while Start=1. Separately, Reset asserted mid-MEM: next cycle IDLE, MemRead=0, InstrCount=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 3-bit-opcode processor.
// Steps each instruction through FETCH / EXEC / MEM / WB (/ SWP2) and
// decodes the per-cycle datapath enables from the current state and Op.
//
// Ports:
//   Clk, Reset          clock (rising edge), synchronous active-high reset
//   Start               begin execution (sampled in IDLE only)
//   Op, Zero            opcode from IR, ALU equality flag
//   MemReady            data memory finished its access this cycle
//   HaltIn              current instruction is the last one
//   IRLoad, PCEn, PCBranch, ALUOp, WriteSrc, RegWrite, RegWriteSel,
//   MemRead, MemWrite   datapath controls (combinational from state/Op)
//   Ack, Err            program finished / memory timeout, held in DONE
//   InstrCount          retired instructions, saturating
module multicycle_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  input  logic             HaltIn,
  output logic             IRLoad,
  output logic             PCEn,
  output logic             PCBranch,
  output logic             ALUOp,
  output logic [1:0]       WriteSrc,
  output logic             RegWrite,
  output logic             RegWriteSel,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Ack,
  output logic             Err,
  output logic [CNT_W-1:0] InstrCount
);

  localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_LWD = 3'b010,
                         OP_SWD = 3'b011, OP_SLT = 3'b100, OP_BEQ = 3'b101,
                         OP_SWP = 3'b110, OP_LIM = 3'b111;

  // DONE is split in two so Ack/Err are pure state decode and clear on exit.
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_SWP2, S_DONE_ACK, S_DONE_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          fin;       // final cycle of the current instruction
  logic [1:0]    ws_dec;
  logic          alu_dec;

  // Opcode decode shared by EXEC and WB (same encoding as the single-cycle decoder).
  always_comb begin
    ws_dec  = 2'b11;
    alu_dec = 1'b0;
    case (Op)
      OP_ADD: ws_dec = 2'b00;
      OP_SUB: begin ws_dec = 2'b00; alu_dec = 1'b1; end
      OP_LWD: ws_dec = 2'b01;
      OP_SLT: ws_dec = 2'b10;
      OP_BEQ: alu_dec = 1'b1;
      default: ;  // swd, swp, lim: 11 / add
    endcase
  end

  always_comb begin
    state_nxt   = state;
    fin         = 1'b0;
    IRLoad      = 1'b0;
    PCEn        = 1'b0;
    PCBranch    = 1'b0;
    ALUOp       = 1'b0;
    WriteSrc    = 2'b11;
    RegWrite    = 1'b0;
    RegWriteSel = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Ack         = 1'b0;
    Err         = 1'b0;
    case (state)
      S_IDLE: if (Start) state_nxt = S_FETCH;
      S_FETCH: begin
        IRLoad    = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        ALUOp    = alu_dec;
        WriteSrc = ws_dec;
        case (Op)
          OP_LWD, OP_SWD: state_nxt = S_MEM;
          OP_BEQ: begin
            PCEn     = 1'b1;
            PCBranch = Zero;
            fin      = 1'b1;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        MemRead  = (Op == OP_LWD);
        MemWrite = (Op != OP_LWD);
        // A ready in the last tolerated cycle still completes the access.
        if (MemReady) begin
          if (Op == OP_LWD) state_nxt = S_WB;
          else begin
            PCEn = 1'b1;
            fin  = 1'b1;
          end
        end else if (wait_cnt == WMAX) begin
          state_nxt = S_DONE_ERR;
        end
      end
      S_WB: begin
        // ALU result was captured at the end of EXEC, so ALUOp stays at default.
        RegWrite = 1'b1;
        WriteSrc = ws_dec;
        if (Op == OP_SWP) state_nxt = S_SWP2;
        else begin
          PCEn = 1'b1;
          fin  = 1'b1;
        end
      end
      S_SWP2: begin
        RegWrite    = 1'b1;
        RegWriteSel = 1'b1;
        PCEn        = 1'b1;
        fin         = 1'b1;
      end
      S_DONE_ACK: begin
        Ack = 1'b1;
        if (!Start) state_nxt = S_IDLE;
      end
      S_DONE_ERR: begin
        Err = 1'b1;
        if (!Start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (fin) state_nxt = HaltIn ? S_DONE_ACK : S_FETCH;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      InstrCount <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC)
        wait_cnt <= '0;
      else if (state == S_MEM && !MemReady && wait_cnt != WMAX)
        wait_cnt <= wait_cnt + 1'b1;
      if (fin && InstrCount != {CNT_W{1'b1}})
        InstrCount <= InstrCount + 1'b1;
    end
  end

endmodule
